instruction_memory_ctrl: RTL and testbench

Parametrised successor to the CPU's instruction store. It holds DEPTH words of WORD_SIZE bits, default 19-bit CPU words. It has a registered fetch port with a valid handshake and a program-load port with a write acknowledge. Memory is cleared by a post-reset init state machine, one word per cycle, instead of a whole-array reset. It sits between the fetch stage (instruction bus) and the loader/debug path (control and address buses).

---
 rtl/instruction_memory_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_instruction_memory_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_ctrl.sv
// -----------------------------------------------------------------------------
// instruction_memory_ctrl
//
// Instruction store that sits between the fetch stage and the loader/debug
// path. It holds DEPTH words of WORD_SIZE bits. DEPTH does not have to be a
// power of two.
//
// After reset, a small state machine clears the array one word per cycle
// (INIT) and then stays in IDLE. A registered fetch port returns data one
// cycle after a request is accepted. A program-load port writes a word and
// acknowledges it on the following cycle.
//
// Optional build macro: PARITY_CHECK_EN
//    - When defined, each word carries an extra even-parity bit.
//    - The bit is checked on every in-range fetch.
//
// Ports:
//    CLK          clock, rising edge
//    RESET        asynchronous active-low reset
//    fetch_req    fetch request (accepted when fetch_ready)
//    fetch_addr   fetch word address
//    fetch_ready  fetch port can accept a request (state decode)
//    instr_valid  instr_out holds a freshly fetched word this cycle
//    instr_out    fetched instruction (holds when no fetch completes)
//    load_req     program-load write request (accepted when !busy_init)
//    load_addr    write address
//    load_data    write data
//    load_ack     one-cycle acknowledge for each accepted load
//    busy_init    init clear in progress (state decode)
//    addr_err     one-cycle pulse for an out-of-range fetch or load
//    parity_err   parity mismatch on a fetch (0 unless PARITY_CHECK_EN)
// -----------------------------------------------------------------------------
module instruction_memory_ctrl #(
   parameter int WORD_SIZE      = 19,
   parameter int DEPTH          = 1024,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 fetch_req,
   input  logic [ADDR_W-1:0]    fetch_addr,
   output logic                 fetch_ready,
   output logic                 instr_valid,
   output logic [WORD_SIZE-1:0] instr_out,
   input  logic                 load_req,
   input  logic [ADDR_W-1:0]    load_addr,
   input  logic [WORD_SIZE-1:0] load_data,
   output logic                 load_ack,
   output logic                 busy_init,
   output logic                 addr_err,
   output logic                 parity_err
);

`ifdef PARITY_CHECK_EN
   localparam int MEM_W = WORD_SIZE + 1;   // parity bit sits in the MSB
`else
   localparam int MEM_W = WORD_SIZE;
`endif

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t               state;
   logic [ADDR_W-1:0]    init_cnt;
   logic [MEM_W-1:0]     mem [0:DEPTH-1];
   logic [WORD_SIZE-1:0] rd_word;
   logic                 valid_q;
   logic                 ack_q;
   logic                 err_q;
   logic                 out_zero;    // instr_out forced to 0 (reset / out-of-range fetch)

   logic                 fetch_acc;
   logic                 load_acc;
   logic                 fetch_in_range;
   logic                 load_in_range;
   logic [MEM_W-1:0]     load_word;

   // Gating with RESET prevents any array write or read capture while the
   // controller is held in reset, including when CLEAR_ON_RESET=0.
   always_comb begin
      fetch_acc      = fetch_req && (state == ST_IDLE) && RESET;
      load_acc       = load_req  && (state == ST_IDLE) && RESET;
      fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
      load_in_range  = ({1'b0, load_addr}  < DEPTH_L);
`ifdef PARITY_CHECK_EN
      load_word      = {^load_data, load_data};
`else
      load_word      = load_data;
`endif
   end

   // -------------------------------------------------------------------------
   // Storage
   //
   // The storage has no reset, so it can map onto block RAM.
   // INIT and load share the single write port. Loads are never accepted
   // during INIT, so the two writers never conflict.
   //
   // The read uses the pre-edge contents of the array. This gives
   // read-before-write behaviour when a fetch and a load hit the same
   // address on the same edge.
   // -------------------------------------------------------------------------
`ifdef PARITY_CHECK_EN
   logic rd_par;
`endif

   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         mem[init_cnt] <= '0;
      end else if (load_acc && load_in_range) begin
         mem[load_addr] <= load_word;
      end
      if (fetch_acc && fetch_in_range) begin
         rd_word <= mem[fetch_addr][WORD_SIZE-1:0];
`ifdef PARITY_CHECK_EN
         rd_par  <= mem[fetch_addr][WORD_SIZE];
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Control state machine and handshake registers
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
         init_cnt <= '0;
         valid_q  <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         out_zero <= 1'b1;
      end else begin
         valid_q <= fetch_acc;
         ack_q   <= load_acc;
         err_q   <= (fetch_acc && !fetch_in_range) || (load_acc && !load_in_range);

         // instr_out only changes when a fetch completes.
         // Otherwise it keeps its last value.
         if (fetch_acc) begin
            out_zero <= !fetch_in_range;
         end

         case (state)
            ST_INIT: begin
               if (init_cnt == LAST_L) begin
                  init_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            default: ;   // IDLE is left only through reset
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   //
   // Every output below is either a register or a decode of registers.
   // There is no path from an input to any of them.
   // -------------------------------------------------------------------------
   assign busy_init   = (state == ST_INIT);
   assign fetch_ready = (state == ST_IDLE);
   assign instr_valid = valid_q;
   assign load_ack    = ack_q;
   assign addr_err    = err_q;
   assign instr_out   = out_zero ? '0 : rd_word;

`ifdef PARITY_CHECK_EN
   // Even parity over data plus stored bit must be 0.
   // out_zero masks out-of-range fetches, whose captured data is stale.
   assign parity_err  = valid_q && !out_zero && (^{rd_par, rd_word});
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
module tb_instruction_memory_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;

   // DUT A: DEPTH=1024
   logic        fetch_req_a, load_req_a;
   logic [9:0]  fetch_addr_a, load_addr_a;
   logic [18:0] load_data_a;
   logic        fetch_ready_a, instr_valid_a, load_ack_a, busy_init_a, addr_err_a, parity_err_a;
   logic [18:0] instr_out_a;

   // DUT B: DEPTH=1000 (non power of two)
   logic        fetch_req_b, load_req_b;
   logic [9:0]  fetch_addr_b, load_addr_b;
   logic [18:0] load_data_b;
   logic        fetch_ready_b, instr_valid_b, load_ack_b, busy_init_b, addr_err_b, parity_err_b;
   logic [18:0] instr_out_b;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   instruction_memory_ctrl #(.WORD_SIZE(19), .DEPTH(1024), .CLEAR_ON_RESET(1'b1)) dut (
      .CLK(CLK), .RESET(RESET),
      .fetch_req(fetch_req_a), .fetch_addr(fetch_addr_a), .fetch_ready(fetch_ready_a),
      .instr_valid(instr_valid_a), .instr_out(instr_out_a),
      .load_req(load_req_a), .load_addr(load_addr_a), .load_data(load_data_a),
      .load_ack(load_ack_a), .busy_init(busy_init_a), .addr_err(addr_err_a),
      .parity_err(parity_err_a)
   );

   instruction_memory_ctrl #(.WORD_SIZE(19), .DEPTH(1000), .CLEAR_ON_RESET(1'b1)) dut_b (
      .CLK(CLK), .RESET(RESET),
      .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b), .fetch_ready(fetch_ready_b),
      .instr_valid(instr_valid_b), .instr_out(instr_out_b),
      .load_req(load_req_b), .load_addr(load_addr_b), .load_data(load_data_b),
      .load_ack(load_ack_b), .busy_init(busy_init_b), .addr_err(addr_err_b),
      .parity_err(parity_err_b)
   );

   typedef struct {
      bit          b;        // 1 = drive/check DUT B
      bit          f_req;
      logic [9:0]  f_addr;
      bit          l_req;
      logic [9:0]  l_addr;
      logic [18:0] l_data;
      bit          e_valid;
      logic [18:0] e_out;
      bit          e_ack;
      bit          e_err;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_req_a = 0; load_req_a = 0; fetch_req_b = 0; load_req_b = 0;
   endtask

   // Counts cycles with busy_init high on both DUTs, starting at reset release.
   task automatic measure_init(output int n_a, output int n_b, output bit ack_seen, output bit valid_seen);
      n_a = 0; n_b = 0; ack_seen = 0; valid_seen = 0;
      while ((busy_init_a || busy_init_b) && n_a < 2000) begin
         if (busy_init_a) n_a++;
         if (busy_init_b) n_b++;
         if (load_ack_a || load_ack_b) ack_seen = 1;
         if (instr_valid_a || instr_valid_b) valid_seen = 1;
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1);
   end

   initial begin
      int n_a, n_b;
      bit ack_seen, valid_seen;
      vec_t v;

      //                b  freq faddr    lreq laddr    ldata       valid out        ack err
      vecs[0]  = '{0, 1, 10'd1023, 0, 10'd0,    19'h00000, 1, 19'h00000, 0, 0};
      vecs[1]  = '{0, 0, 10'd0,    1, 10'd5,    19'h7ABCD, 0, 19'h00000, 1, 0};
      vecs[2]  = '{0, 1, 10'd5,    0, 10'd0,    19'h00000, 1, 19'h7ABCD, 0, 0};
      vecs[3]  = '{0, 0, 10'd0,    0, 10'd0,    19'h00000, 0, 19'h7ABCD, 0, 0};
      vecs[4]  = '{0, 1, 10'd9,    1, 10'd9,    19'h12345, 1, 19'h00000, 1, 0};
      vecs[5]  = '{0, 1, 10'd9,    0, 10'd0,    19'h00000, 1, 19'h12345, 0, 0};
      vecs[6]  = '{0, 1, 10'd5,    1, 10'd5,    19'h05555, 1, 19'h7ABCD, 1, 0};
      vecs[7]  = '{0, 1, 10'd5,    1, 10'd6,    19'h3FFFF, 1, 19'h05555, 1, 0};
      vecs[8]  = '{0, 1, 10'd6,    0, 10'd0,    19'h00000, 1, 19'h3FFFF, 0, 0};
      vecs[9]  = '{0, 0, 10'd0,    1, 10'd0,    19'h00001, 0, 19'h3FFFF, 1, 0};
      vecs[10] = '{0, 1, 10'd0,    0, 10'd0,    19'h00000, 1, 19'h00001, 0, 0};
      vecs[11] = '{1, 1, 10'd1010, 0, 10'd0,    19'h00000, 1, 19'h00000, 0, 1};
      vecs[12] = '{1, 0, 10'd0,    0, 10'd0,    19'h00000, 0, 19'h00000, 0, 0};
      vecs[13] = '{1, 0, 10'd0,    1, 10'd1010, 19'h7FFFF, 0, 19'h00000, 1, 1};
      vecs[14] = '{1, 1, 10'd986,  0, 10'd0,    19'h00000, 1, 19'h00000, 0, 0};
      vecs[15] = '{1, 0, 10'd0,    1, 10'd999,  19'h00ABC, 0, 19'h00000, 1, 0};
      vecs[16] = '{1, 1, 10'd999,  0, 10'd0,    19'h00000, 1, 19'h00ABC, 0, 0};
      vecs[17] = '{1, 1, 10'd1010, 0, 10'd0,    19'h00000, 1, 19'h00000, 0, 1};
      vecs[18] = '{1, 1, 10'd986,  0, 10'd0,    19'h00000, 1, 19'h00000, 0, 0};

      // ---------------- reset and INIT length ----------------
      RESET = 0;
      idle_inputs();
      fetch_addr_a = 10'd1023; load_addr_a = 10'd7; load_data_a = 19'h00012;
      fetch_addr_b = '0; load_addr_b = '0; load_data_b = '0;
      fetch_req_a = 1; load_req_a = 1;          // held through INIT, must be ignored
      #12;
      check("rst_valid",  instr_valid_a, 0);
      check("rst_out",    instr_out_a,   0);
      check("rst_ack",    load_ack_a,    0);
      check("rst_err",    addr_err_a,    0);
      check("rst_busy",   busy_init_a,   1);
      check("rst_ready",  fetch_ready_a, 0);
      check("rst_parity", parity_err_a,  0);
      step();
      RESET = 1;
      measure_init(n_a, n_b, ack_seen, valid_seen);
      $display("init: busy cycles a=%0d b=%0d", n_a, n_b);
      check("init_len_1024", n_a, 1024);
      check("init_len_1000", n_b, 1000);
      check("init_no_ack",   ack_seen, 0);
      check("init_no_valid", valid_seen, 0);
      check("idle_ready",    fetch_ready_a, 1);
      check("idle_busy",     busy_init_a, 0);

      // ---------------- table-driven transactions ----------------
      for (int i = 0; i < 19; i++) begin
         v = vecs[i];
         fetch_req_a = !v.b && v.f_req; fetch_addr_a = v.f_addr;
         load_req_a  = !v.b && v.l_req; load_addr_a  = v.l_addr; load_data_a = v.l_data;
         fetch_req_b =  v.b && v.f_req; fetch_addr_b = v.f_addr;
         load_req_b  =  v.b && v.l_req; load_addr_b  = v.l_addr; load_data_b = v.l_data;
         step();
         if (!v.b) begin
            $display("vec %0d a: valid=%0d out=%h ack=%0d err=%0d", i, instr_valid_a, instr_out_a, load_ack_a, addr_err_a);
            check($sformatf("v%0d_valid", i), instr_valid_a, v.e_valid);
            check($sformatf("v%0d_out", i),   instr_out_a,   v.e_out);
            check($sformatf("v%0d_ack", i),   load_ack_a,    v.e_ack);
            check($sformatf("v%0d_err", i),   addr_err_a,    v.e_err);
            check($sformatf("v%0d_par", i),   parity_err_a,  0);
         end else begin
            $display("vec %0d b: valid=%0d out=%h ack=%0d err=%0d", i, instr_valid_b, instr_out_b, load_ack_b, addr_err_b);
            check($sformatf("v%0d_valid", i), instr_valid_b, v.e_valid);
            check($sformatf("v%0d_out", i),   instr_out_b,   v.e_out);
            check($sformatf("v%0d_ack", i),   load_ack_b,    v.e_ack);
            check($sformatf("v%0d_err", i),   addr_err_b,    v.e_err);
            check($sformatf("v%0d_par", i),   parity_err_b,  0);
         end
      end
      idle_inputs();

      // ---------------- async reset mid-transfer ----------------
      fetch_req_a = 1; fetch_addr_a = 10'd5;
      load_req_a = 1;  load_addr_a = 10'd8; load_data_a = 19'h00002;
      step();
      $display("pre-reset: valid=%0d out=%h ack=%0d", instr_valid_a, instr_out_a, load_ack_a);
      check("pre_rst_valid", instr_valid_a, 1);
      check("pre_rst_out",   instr_out_a,   19'h05555);
      check("pre_rst_ack",   load_ack_a,    1);
      #2 RESET = 0;
      #1;
      $display("async reset: valid=%0d out=%h ack=%0d", instr_valid_a, instr_out_a, load_ack_a);
      check("async_valid", instr_valid_a, 0);
      check("async_out",   instr_out_a,   0);
      check("async_ack",   load_ack_a,    0);
      check("async_busy",  busy_init_a,   1);
      idle_inputs();
      step();
      RESET = 1;

      // ---------------- reset at INIT cycle 300 ----------------
      repeat (300) step();
      check("init300_busy", busy_init_a, 1);
      RESET = 0;
      repeat (2) step();
      RESET = 1;
      measure_init(n_a, n_b, ack_seen, valid_seen);
      $display("re-init: busy cycles a=%0d", n_a);
      check("reinit_len", n_a, 1024);

      // Memory must have been cleared by the restarted INIT
      fetch_req_a = 1; fetch_addr_a = 10'd5;
      step();
      $display("post-init fetch 5: valid=%0d out=%h", instr_valid_a, instr_out_a);
      check("clr5_valid", instr_valid_a, 1);
      check("clr5_out",   instr_out_a,   0);
      fetch_addr_a = 10'd8;
      step();
      $display("post-init fetch 8: valid=%0d out=%h", instr_valid_a, instr_out_a);
      check("clr8_out", instr_out_a, 0);
      idle_inputs();

`ifdef PARITY_CHECK_EN
      // ---------------- parity corruption ----------------
      load_req_a = 1; load_addr_a = 10'd3; load_data_a = 19'h00001;
      step();
      load_req_a = 0; fetch_req_a = 1; fetch_addr_a = 10'd3;
      step();
      $display("parity clean: valid=%0d out=%h perr=%0d", instr_valid_a, instr_out_a, parity_err_a);
      check("par_clean", parity_err_a, 0);
      fetch_req_a = 0;
      dut.mem[3][19] = ~dut.mem[3][19];
      fetch_req_a = 1;
      step();
      $display("parity flipped: valid=%0d out=%h perr=%0d", instr_valid_a, instr_out_a, parity_err_a);
      check("par_err",   parity_err_a,  1);
      check("par_valid", instr_valid_a, 1);
      check("par_out",   instr_out_a,   19'h00001);
      idle_inputs();
      step();
      check("par_clear", parity_err_a, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
